// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU I/D memory arbiter: FSM states,
// requester ids and performance-counter layout.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_e;

    // Performance counter bank layout (used only with ARB_PERF_CNT_EN).
    localparam int PERF_W      = 32;
    localparam int PERF_N      = 3;
    localparam int PERF_ISTALL = 0;
    localparam int PERF_DSTALL = 1;
    localparam int PERF_BUSY   = 2;

endpackage

// File: rtl/cpu_mem_arbiter_if.sv
// Bus bundle between CPU core, arbiter and unified memory.
// slave  = arbiter view, master = CPU/memory environment view.
interface cpu_mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    // instruction fetch port
    logic          i_req_valid;
    logic          i_req_ready;
    logic [AW-1:0] i_addr;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    // data port
    logic          d_req_valid;
    logic          d_req_ready;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    // memory port
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  i_req_valid, i_addr, d_req_valid, d_we, d_addr, d_wdata, mem_rdata,
        output i_req_ready, i_rvalid, i_rdata, d_req_ready, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req_valid, i_addr, d_req_valid, d_we, d_addr, d_wdata, mem_rdata,
        input  i_req_ready, i_rvalid, i_rdata, d_req_ready, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arb_perf_ctr.sv
// Bank of N saturating event counters, cleared by synchronous reset.
module mem_arb_perf_ctr #(
    parameter int N = 3,
    parameter int W = 32
) (
    input  logic                clk,
    input  logic                pc_rst,
    input  logic [N-1:0]        inc,
    output logic [N-1:0][W-1:0] cnt
);

    for (genvar g = 0; g < N; g++) begin : g_ctr
        logic [W-1:0] c_q;

        // count events, sticking at all-ones instead of wrapping
        always_ff @(posedge clk) begin
            if (pc_rst)
                c_q <= '0;
            else if (inc[g] && (c_q != {W{1'b1}}))
                c_q <= c_q + 1'b1;
        end

        assign cnt[g] = c_q;
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Arbitrates one single-port synchronous memory between the CPU fetch (I)
// and data (D) ports. One transaction in flight:
//   IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP -> IDLE.
// D wins ties unless I has been passed over STARVE_MAX times in a row.
// Optional build macro ARB_PERF_CNT_EN adds stall/busy counters.
module cpu_mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int AW         = 16,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              pc_rst,
    cpu_mem_arbiter_if.slave  bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] perf_i_stall,
    output logic [PERF_W-1:0] perf_d_stall,
    output logic [PERF_W-1:0] perf_busy
`endif
);

    localparam int WCW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SCW = $clog2(STARVE_MAX + 2);

    state_e          state_q, state_d;
    logic [WCW-1:0]  wait_cnt_q;
    logic [SCW-1:0]  starve_cnt_q;
    req_id_e         id_q;
    logic            we_q;
    logic            mem_en_q, mem_we_q;
    logic [AW-1:0]   mem_addr_q;
    logic [DW-1:0]   mem_wdata_q;
    logic            i_rvalid_q, d_rvalid_q;
    logic [DW-1:0]   i_rdata_q, d_rdata_q;

    logic starve_hit, grant_i, grant_d, idle_ok;
    logic acc_i, acc_d, acc, last_wait;

    // Arbitration: D by default; I once it has lost STARVE_MAX times in a row.
    assign starve_hit = (starve_cnt_q == SCW'(STARVE_MAX));
    assign grant_d    = bus.d_req_valid && (!bus.i_req_valid || !starve_hit);
    assign grant_i    = bus.i_req_valid && !grant_d;
    assign idle_ok    = (state_q == ST_IDLE) && !pc_rst;

    assign bus.i_req_ready = idle_ok && grant_i;
    assign bus.d_req_ready = idle_ok && grant_d;

    assign acc_i     = bus.i_req_ready;
    assign acc_d     = bus.d_req_ready;
    assign acc       = acc_i || acc_d;
    assign last_wait = (state_q == ST_WAIT) && (wait_cnt_q == WCW'(MEM_LAT - 1));

    // Next-state logic; reset always lands in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (acc) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (last_wait) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (pc_rst) state_d = ST_IDLE;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (pc_rst) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Counts WAIT cycles so the memory word is captured on the last one.
    always_ff @(posedge clk) begin
        if (pc_rst || state_q != ST_WAIT) wait_cnt_q <= '0;
        else                              wait_cnt_q <= wait_cnt_q + 1'b1;
    end

    // Latch the winning request and drive the memory strobe in the ISSUE cycle;
    // address/wdata hold their last value between transactions.
    always_ff @(posedge clk) begin
        if (pc_rst) begin
            id_q        <= REQ_I;
            we_q        <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_en_q <= acc;
            mem_we_q <= acc_d && bus.d_we;
            if (acc) begin
                id_q       <= acc_d ? REQ_D : REQ_I;
                we_q       <= acc_d && bus.d_we;
                mem_addr_q <= acc_d ? bus.d_addr : bus.i_addr;
                if (acc_d) mem_wdata_q <= bus.d_wdata;
            end
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    // Capture memory data on the last WAIT cycle; rvalid is high for the RESP cycle.
    always_ff @(posedge clk) begin
        if (pc_rst) begin
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            i_rvalid_q <= last_wait && (id_q == REQ_I);
            d_rvalid_q <= last_wait && (id_q == REQ_D);
            if (last_wait) begin
                if (id_q == REQ_I) i_rdata_q <= bus.mem_rdata;
                else               d_rdata_q <= we_q ? '0 : bus.mem_rdata;
            end
        end
    end

    assign bus.i_rvalid = i_rvalid_q;
    assign bus.d_rvalid = d_rvalid_q;
    assign bus.i_rdata  = i_rdata_q;
    assign bus.d_rdata  = d_rdata_q;

    // Starvation counter: D wins while I waits bump it; I winning, or I not
    // asking during an IDLE cycle, clears it.
    always_ff @(posedge clk) begin
        if (pc_rst)
            starve_cnt_q <= '0;
        else if (state_q == ST_IDLE) begin
            if (acc_i)
                starve_cnt_q <= '0;
            else if (acc_d && bus.i_req_valid) begin
                if (!starve_hit) starve_cnt_q <= starve_cnt_q + 1'b1;
            end else if (!bus.i_req_valid)
                starve_cnt_q <= '0;
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [PERF_N-1:0]             perf_inc;
    logic [PERF_N-1:0][PERF_W-1:0] perf_cnt;

    // The accept cycle counts as busy, so a saturated stream reads MEM_LAT+3 per transaction.
    assign perf_inc[PERF_ISTALL] = bus.i_req_valid && !bus.i_req_ready;
    assign perf_inc[PERF_DSTALL] = bus.d_req_valid && !bus.d_req_ready;
    assign perf_inc[PERF_BUSY]   = (state_q != ST_IDLE) || acc;

    mem_arb_perf_ctr #(.N(PERF_N), .W(PERF_W)) u_perf (
        .clk    (clk),
        .pc_rst (pc_rst),
        .inc    (perf_inc),
        .cnt    (perf_cnt)
    );

    assign perf_i_stall = perf_cnt[PERF_ISTALL];
    assign perf_d_stall = perf_cnt[PERF_DSTALL];
    assign perf_busy    = perf_cnt[PERF_BUSY];
`endif

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter with a response scoreboard.
// u_dut: MEM_LAT=1, u_dut2: MEM_LAT=2 (back-to-back timing only).
module tb_cpu_mem_arbiter;

    logic clk = 1'b0;
    logic pc_rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    cpu_mem_arbiter_if #(.AW(16), .DW(32)) bus1 ();
    cpu_mem_arbiter_if #(.AW(16), .DW(32)) bus2 ();

`ifdef ARB_PERF_CNT_EN
    logic [31:0] p1_i, p1_d, p1_b, p2_i, p2_d, p2_b;
`endif

    cpu_mem_arbiter #(.AW(16), .DW(32), .MEM_LAT(1), .STARVE_MAX(3)) u_dut (
        .clk    (clk),
        .pc_rst (pc_rst),
        .bus    (bus1)
`ifdef ARB_PERF_CNT_EN
        , .perf_i_stall(p1_i), .perf_d_stall(p1_d), .perf_busy(p1_b)
`endif
    );

    cpu_mem_arbiter #(.AW(16), .DW(32), .MEM_LAT(2), .STARVE_MAX(3)) u_dut2 (
        .clk    (clk),
        .pc_rst (pc_rst),
        .bus    (bus2)
`ifdef ARB_PERF_CNT_EN
        , .perf_i_stall(p2_i), .perf_d_stall(p2_d), .perf_busy(p2_b)
`endif
    );

    function automatic logic [31:0] pat(input logic [7:0] a);
        return {16'hA5C3, 8'h00, a};
    endfunction

    // memory models: LAT1 for u_dut, LAT2 for u_dut2
    logic [31:0] mem1 [0:255];
    logic [31:0] mem2 [0:255];
    logic [31:0] ref_mem [0:255];
    logic [31:0] rd1, rd2a, rd2b;

    initial begin
        for (int k = 0; k < 256; k++) begin
            mem1[k]    = pat(8'(k));
            mem2[k]    = pat(8'(k));
            ref_mem[k] = pat(8'(k));
        end
    end

    always @(posedge clk) begin
        if (bus1.mem_en) begin
            if (bus1.mem_we) mem1[bus1.mem_addr[7:0]] = bus1.mem_wdata;
            rd1 <= mem1[bus1.mem_addr[7:0]];
        end
    end
    assign bus1.mem_rdata = rd1;

    always @(posedge clk) begin
        if (bus2.mem_en) begin
            if (bus2.mem_we) mem2[bus2.mem_addr[7:0]] = bus2.mem_wdata;
            rd2a <= mem2[bus2.mem_addr[7:0]];
        end
        rd2b <= rd2a;
    end
    assign bus2.mem_rdata = rd2b;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard for u_dut
    typedef struct {
        bit          id;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];
    bit   glog[$];
    int   i_rsp_cnt = 0;
    int   d_rsp_cnt = 0;

    always @(negedge clk) begin
        if (pc_rst) begin
            sb.delete();
        end else begin
            if (bus1.i_rvalid || bus1.d_rvalid) begin
                chk("rsp_pending", sb.size(), 1);
                chk("rsp_one_side", bus1.i_rvalid && bus1.d_rvalid, 0);
                if (bus1.i_rvalid) i_rsp_cnt++;
                if (bus1.d_rvalid) d_rsp_cnt++;
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_id", bus1.d_rvalid, e.id);
                    chk("rsp_data", bus1.d_rvalid ? bus1.d_rdata : bus1.i_rdata, e.data);
                end
            end
            if (bus1.i_req_valid && bus1.i_req_ready) begin
                sb.push_back('{1'b0, ref_mem[bus1.i_addr[7:0]]});
                glog.push_back(1'b0);
            end
            if (bus1.d_req_valid && bus1.d_req_ready) begin
                if (bus1.d_we) begin
                    ref_mem[bus1.d_addr[7:0]] = bus1.d_wdata;
                    sb.push_back('{1'b1, 32'h0});
                end else begin
                    sb.push_back('{1'b1, ref_mem[bus1.d_addr[7:0]]});
                end
                glog.push_back(1'b1);
            end
        end
    end

    task automatic send(input bit is_d, input bit we, input logic [15:0] a, input logic [31:0] wd);
        bit got = 0;
        if (is_d) begin
            bus1.d_req_valid = 1; bus1.d_we = we; bus1.d_addr = a; bus1.d_wdata = wd;
        end else begin
            bus1.i_req_valid = 1; bus1.i_addr = a;
        end
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (is_d ? bus1.d_req_ready : bus1.i_req_ready) begin
                got = 1;
                break;
            end
        end
        chk("accept_in_time", got, 1);
        @(posedge clk); #1;
        bus1.d_req_valid = 0;
        bus1.i_req_valid = 0;
    endtask

    task automatic drain();
        for (int c = 0; c < 50; c++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, i0, il, dl;
        bit ia, da, got;
        bit exp_g [5];
        int rdy[$];
        int rv[$];

        bus1.i_req_valid = 1; bus1.i_addr = 16'h0; bus1.d_req_valid = 1;
        bus1.d_we = 0; bus1.d_addr = 16'h0; bus1.d_wdata = 32'h0;
        bus2.i_req_valid = 0; bus2.i_addr = 16'h0; bus2.d_req_valid = 0;
        bus2.d_we = 0; bus2.d_addr = 16'h0; bus2.d_wdata = 32'h0;

        // reset state, readies held low while reset is high
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_i_ready", bus1.i_req_ready, 0);
        chk("rst_d_ready", bus1.d_req_ready, 0);
        chk("rst_mem_en", bus1.mem_en, 0);
        chk("rst_mem_we", bus1.mem_we, 0);
        chk("rst_mem_addr", bus1.mem_addr, 0);
        chk("rst_mem_wdata", bus1.mem_wdata, 0);
        chk("rst_rvalid", {bus1.i_rvalid, bus1.d_rvalid}, 0);
        chk("rst_i_rdata", bus1.i_rdata, 0);
        chk("rst_d_rdata", bus1.d_rdata, 0);
        @(posedge clk); #1;
        bus1.i_req_valid = 0; bus1.d_req_valid = 0; pc_rst = 0;

        // single fetch timing, MEM_LAT=1
        bus1.i_req_valid = 1; bus1.i_addr = 16'h0010;
        @(negedge clk); chk("f_ready_c0", bus1.i_req_ready, 1);
        @(posedge clk); #1; bus1.i_req_valid = 0;
        @(negedge clk);
        chk("f_mem_en_c1", bus1.mem_en, 1);
        chk("f_mem_addr_c1", bus1.mem_addr, 16'h0010);
        chk("f_mem_we_c1", bus1.mem_we, 0);
        @(negedge clk);
        chk("f_mem_en_c2", bus1.mem_en, 0);
        chk("f_rvalid_c2", bus1.i_rvalid, 0);
        @(negedge clk);
        chk("f_rvalid_c3", bus1.i_rvalid, 1);
        chk("f_rdata_c3", bus1.i_rdata, pat(8'h10));
        @(negedge clk);
        chk("f_rvalid_c4", bus1.i_rvalid, 0);
        @(posedge clk); #1;

        // D write then read back
        d0 = d_rsp_cnt; i0 = i_rsp_cnt;
        send(1, 1, 16'h0020, 32'hDEADBEEF);
        @(negedge clk);
        chk("w_mem_we", bus1.mem_we, 1);
        chk("w_mem_wdata", bus1.mem_wdata, 32'hDEADBEEF);
        drain();
        send(1, 0, 16'h0020, 32'h0);
        drain();
        chk("wr_d_rsp", d_rsp_cnt - d0, 2);
        chk("wr_i_rsp", i_rsp_cnt - i0, 0);
        chk("wr_rdata", bus1.d_rdata, 32'hDEADBEEF);

        // starvation: I held over D stream; also clears perf counters first
        @(posedge clk); #1; pc_rst = 1;
        @(posedge clk); #1; pc_rst = 0;
        glog.delete();
        il = 1; dl = 4;
        bus1.i_req_valid = 1; bus1.i_addr = 16'h0030;
        bus1.d_req_valid = 1; bus1.d_we = 0; bus1.d_addr = 16'h0040;
        for (int c = 0; c < 60 && (il > 0 || dl > 0); c++) begin
            @(negedge clk);
            ia = bus1.i_req_valid && bus1.i_req_ready;
            da = bus1.d_req_valid && bus1.d_req_ready;
            @(posedge clk); #1;
            if (ia) begin il--; if (il == 0) bus1.i_req_valid = 0; end
            if (da) begin dl--; if (dl == 0) bus1.d_req_valid = 0; end
        end
        chk("starve_done", {il[7:0], dl[7:0]}, 0);
        drain();
        exp_g = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        chk("starve_glen", glog.size(), 5);
        for (int k = 0; k < 5 && k < glog.size(); k++)
            chk($sformatf("starve_g%0d", k), glog[k], exp_g[k]);
`ifdef ARB_PERF_CNT_EN
        chk("perf_i_stall", p1_i, 12);
        chk("perf_d_stall", p1_d, 13);
        chk("perf_busy", p1_b, 20);
`endif

        // pc_rst pulsed in WAIT drops the transaction
        bus1.d_req_valid = 1; bus1.d_we = 0; bus1.d_addr = 16'h0044;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus1.d_req_ready) begin got = 1; break; end
        end
        chk("rw_accept", got, 1);
        @(posedge clk); #1;            // ISSUE, requester re-presents
        @(posedge clk); #1; pc_rst = 1; // WAIT
        @(negedge clk);
        chk("rw_ready_in_rst", bus1.d_req_ready, 0);
        @(posedge clk); #1; pc_rst = 0;
        @(negedge clk);
        chk("rw_mem_en", bus1.mem_en, 0);
        chk("rw_no_rvalid", {bus1.i_rvalid, bus1.d_rvalid}, 0);
        chk("rw_idle_ready", bus1.d_req_ready, 1);
        @(posedge clk); #1; bus1.d_req_valid = 0;
        d0 = d_rsp_cnt;
        drain();
        chk("rw_reissue_rsp", d_rsp_cnt - d0, 1);
        chk("rw_reissue_data", bus1.d_rdata, pat(8'h44));

        // back-to-back D reads on MEM_LAT=2
        bus2.d_req_valid = 1; bus2.d_we = 0; bus2.d_addr = 16'h0055;
        for (int c = 0; c < 26; c++) begin
            @(negedge clk);
            if (bus2.d_req_ready) rdy.push_back(c);
            if (bus2.d_rvalid) begin
                rv.push_back(c);
                chk("b2b_data", bus2.d_rdata, pat(8'h55));
            end
            @(posedge clk); #1;
            if (c == 19) bus2.d_req_valid = 0;
        end
        chk("b2b_nrdy", rdy.size(), 4);
        chk("b2b_nrv", rv.size(), 4);
        if (rdy.size() > 0 && rv.size() > 0) chk("b2b_lat", rv[0] - rdy[0], 4);
        for (int k = 1; k < rdy.size(); k++) chk("b2b_rdy_gap", rdy[k] - rdy[k-1], 5);
        for (int k = 1; k < rv.size(); k++) chk("b2b_rv_gap", rv[k] - rv[k-1], 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
